instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch sequencer that feeds the main opcode-decoding Controller. It is the producing end of the opcode interface.
- Owns the PC and issues word fetches to instruction memory over a req/rvalid handshake.
- Presents the fetched instruction and its opcode field to the decoder, and holds it until the datapath signals completion.
- Consumes the decoder's Jump/Branch outputs plus ALU zero to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
IMEM_LAT_MAX, 15, maximum cycles waited for imem_rvalid before a fetch timeout; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request strobe, one cycle per fetch
imem_addr  output  32  word-aligned fetch address (= pc)
imem_rvalid  input  1  instruction data valid
imem_rdata  input  32  instruction word
instr  output  32  held instruction
opcode  output  6  instr[31:26], drives the Controller input
instr_valid  output  1  instr/opcode are valid for execution
pc  output  32  address of the held instruction
pc_plus4  output  32  pc + 4
ex_done  input  1  datapath has completed the held instruction this cycle
jump  input  1  Controller Jump output
branch  input  1  Controller Branch output
zero  input  1  ALU zero flag
fetch_err  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, fetch_err = 0, state = S_REQ.
- FSM states:
  - S_REQ: imem_req = 1 for exactly one cycle with imem_addr = pc; go to S_WAIT.
  - S_WAIT: imem_req = 0; increment the wait counter each cycle.
    - On imem_rvalid: latch instr = imem_rdata, set instr_valid = 1, go to S_ISSUE.
    - If the counter reaches IMEM_LAT_MAX (nonzero) without imem_rvalid: set fetch_err, go to S_HALT.
  - S_ISSUE: hold instr and instr_valid. On ex_done: load next PC, clear instr_valid, go to S_REQ.
  - S_HALT: terminal. imem_req = 0, instr_valid = 0. Exited only by reset.
- imem_rvalid is sampled only in S_WAIT and never in the same cycle as imem_req. It is ignored in all other states.
- Minimum fetch-to-issue latency: 2 cycles (req cycle, rvalid in the next cycle, instr_valid the cycle after).
- Next PC, evaluated in the ex_done cycle, priority in this order:
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}
  - branch & zero: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32
  - otherwise: pc_plus4
- Arithmetic: all PC arithmetic is 32-bit unsigned and wraps. pc = 32'hFFFF_FFFC advances to 0.
- Boundary cases:
  - ex_done outside S_ISSUE is ignored.
  - jump/branch are ignored unless ex_done is high in S_ISSUE.
  - jump and branch both high: jump wins.
  - rst_n asserted mid-fetch: immediate return to reset values. A late rvalid after reset release is ignored because the FSM is in S_REQ.

Optional Feature:
IFU_ILLEGAL_TRAP_EN
- Defined: in S_WAIT, when imem_rvalid is high, the incoming opcode is checked. Any opcode other than 000000, 100011, 101011, 000100, 000010 sets a sticky output illegal_op (extra port, 1 bit, reset 0), leaves instr_valid = 0, and moves the FSM to S_HALT. pc stays at the offending address.
- Undefined: no check, no illegal_op port. Unknown opcodes are issued normally; the decoder outputs all-zero controls.

Decomposition:
- Shared package ifu_pkg:
  - state enum {S_REQ, S_WAIT, S_ISSUE, S_HALT}
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - field-slice widths
- One natural sub-module: ifu_next_pc. Pure combinational; inputs pc, instr, jump, branch, zero; outputs pc_plus4 and next_pc.

Test Plan:
- Reset release, imem_rvalid one cycle after req with rdata = 32'h8C01_0004 (lw) -> imem_addr = 0, instr_valid rises the following cycle, opcode = 6'b100011; ex_done -> next fetch at 0x4.
- Held instr = beq with imm = 16'hFFFE at pc = 0x20; branch = 1, zero = 1, ex_done -> next imem_addr = 0x1C. Same case with zero = 0 -> 0x24.
- Held instr = 32'h0800_0010 (j) at pc = 0x4000_0008; jump = 1, branch = 1, ex_done -> next imem_addr = 0x4000_0040.
- imem_rvalid withheld 15 cycles (IMEM_LAT_MAX = 15) -> fetch_err = 1, FSM in S_HALT, no further imem_req until rst_n pulse.
- Reset during S_ISSUE, plus a stray imem_rvalid in the first cycle after release -> pc = RESET_PC, instr_valid = 0, stray rvalid ignored, single imem_req issued.
- With IFU_ILLEGAL_TRAP_EN: rdata opcode 6'b111111 -> illegal_op = 1, instr_valid stays 0, pc unchanged.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro: IFU_ILLEGAL_TRAP_EN (see instr_fetch_unit).
package ifu_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned JIDX_W   = 26;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } ifu_state_t;

    function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC selection: jump, then taken branch, then sequential. All arithmetic wraps at 2^32.
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        br_off   = {{(32 - IMM_W - 2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
        if (jump)
            next_pc = {pc_plus4[31:28], instr[JIDX_W-1:0], 2'b00};
        else if (branch && zero)
            next_pc = pc_plus4 + br_off;
        else
            next_pc = pc_plus4;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over req/rvalid, holds instr until ex_done.
// Build macro IFU_ILLEGAL_TRAP_EN adds the illegal_op port and halts on unknown opcodes.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_LAT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ex_done,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
`ifdef IFU_ILLEGAL_TRAP_EN
    output logic        illegal_op,
`endif
    output logic        fetch_err
);

    ifu_state_t  state;
    logic [31:0] wait_cnt;
    logic [31:0] next_pc;

    ifu_next_pc u_next_pc (
        .pc       (pc),
        .instr    (instr),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    assign imem_addr = pc;
    assign opcode    = instr[31:26];

    // imem_req is registered, so the first S_REQ after reset spends one cycle raising it;
    // later entries into S_REQ arrive with it already set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
`ifdef IFU_ILLEGAL_TRAP_EN
            illegal_op  <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
`ifdef IFU_ILLEGAL_TRAP_EN
                        if (!is_known_op(imem_rdata[31:26])) begin
                            illegal_op <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= S_ISSUE;
                        end
`else
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
`endif
                    end else if ((IMEM_LAT_MAX != 0) && (wait_cnt == 32'(IMEM_LAT_MAX - 1))) begin
                        fetch_err <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_ISSUE: begin
                    if (ex_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetch/issue traffic.
// Two instances in lockstep: default RESET_PC and a high RESET_PC for the jump-region case.
module tb_instr_fetch_unit;

    localparam logic [31:0] HI_PC = 32'h4000_0008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rvalid, ex_done, jump, branch, zero;
    logic [31:0] imem_rdata;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode;
    logic        imem_req_h, instr_valid_h, fetch_err_h;
    logic [31:0] imem_addr_h, instr_h, pc_h, pc_plus4_h;
    logic [5:0]  opcode_h;
`ifdef IFU_ILLEGAL_TRAP_EN
    logic        illegal_op, illegal_op_h;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] mpc, mpc_h;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_LAT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .ex_done(ex_done),
        .jump(jump), .branch(branch), .zero(zero),
`ifdef IFU_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(HI_PC), .IMEM_LAT_MAX(15)) dut_h (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req_h), .imem_addr(imem_addr_h),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr_h), .opcode(opcode_h),
        .instr_valid(instr_valid_h), .pc(pc_h), .pc_plus4(pc_plus4_h), .ex_done(ex_done),
        .jump(jump), .branch(branch), .zero(zero),
`ifdef IFU_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op_h),
`endif
        .fetch_err(fetch_err_h)
    );

    // Reference next-PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input bit j, input bit b, input bit z);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b && z) begin
            off = $signed(ins[15:0]);
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic clear_inputs();
        imem_rvalid = 1'b0; imem_rdata = '0; ex_done = 1'b0;
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mpc   = 32'h0000_0000;
        mpc_h = HI_PC;
    endtask

    // Advance (bounded) to the negedge where imem_req is visible.
    task automatic wait_req(output bit ok, output logic [31:0] a, output logic [31:0] ah);
        ok = 1'b0; a = '0; ah = '0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1; a = imem_addr; ah = imem_addr_h;
                return;
            end
            @(negedge clk);
        end
    endtask

    // From the req negedge: lat idle wait cycles (with ignored noise), then one rvalid cycle.
    task automatic deliver(input logic [31:0] data, input int lat);
        @(negedge clk);
        for (int i = 0; i < lat; i++) begin
            ex_done = 1'($urandom); jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
            @(negedge clk);
        end
        ex_done = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = data;
        @(negedge clk);
        imem_rvalid = 1'b0; imem_rdata = $urandom;
    endtask

    task automatic execute(input logic [31:0] data, input bit j, input bit b, input bit z);
        ex_done = 1'b1; jump = j; branch = b; zero = z; imem_rvalid = 1'b0;
        @(negedge clk);
        ex_done = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        mpc   = ref_next(mpc, data, j, b, z);
        mpc_h = ref_next(mpc_h, data, j, b, z);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        total++;
        if ({imem_req, instr_valid, fetch_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {imem_req, instr_valid, fetch_err});
        end
        total++;
        if (pc !== 32'h0 || instr !== 32'h0 || pc_plus4 !== 32'h4) begin
            bad++; $display("FAIL reset_regs pc=%h instr=%h pc4=%h want 0/0/4", pc, instr, pc_plus4);
        end
        total++;
        if (pc_h !== HI_PC) begin
            bad++; $display("FAIL reset_pc_param got=%h want=%h", pc_h, HI_PC);
        end
`ifdef IFU_ILLEGAL_TRAP_EN
        total++;
        if (illegal_op !== 1'b0) begin
            bad++; $display("FAIL reset_illegal got=%b want=0", illegal_op);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_lw_latency();
        bit ok; logic [31:0] a, ah;
        apply_reset();
        wait_req(ok, a, ah);
        total++;
        if (!ok || a !== 32'h0) begin
            bad++; $display("FAIL lw_first_req ok=%0d addr=%h want addr=0", ok, a);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL lw_wait_cycle req=%b valid=%b want 0/0", imem_req, instr_valid);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
        @(negedge clk);
        imem_rvalid = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || opcode !== 6'b100011 || instr !== 32'h8C01_0004) begin
            bad++; $display("FAIL lw_issue valid=%b op=%b instr=%h want 1/100011/8c010004",
                            instr_valid, opcode, instr);
        end
        execute(32'h8C01_0004, 1'b0, 1'b0, 1'b0);
        wait_req(ok, a, ah);
        total++;
        if (!ok || a !== 32'h4 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL lw_next_req ok=%0d addr=%h valid=%b want addr=4 valid=0", ok, a, instr_valid);
        end
    endtask

    task automatic test_jump_priority();
        bit ok; logic [31:0] a, ah;
        apply_reset();
        wait_req(ok, a, ah);
        total++;
        if (!ok || ah !== HI_PC) begin
            bad++; $display("FAIL jump_start ok=%0d addr=%h want=%h", ok, ah, HI_PC);
        end
        deliver(32'h0800_0010, 1);
        execute(32'h0800_0010, 1'b1, 1'b1, 1'b1);
        wait_req(ok, a, ah);
        total++;
        if (!ok || ah !== 32'h4000_0040 || a !== 32'h0000_0040) begin
            bad++; $display("FAIL jump_over_branch ok=%0d addr_h=%h addr=%h want 40000040/00000040", ok, ah, a);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        j, b, z;
        logic [31:0] exp;
    } step_t;

    task automatic test_next_pc_table();
        step_t tbl[10];
        bit ok; logic [31:0] a, ah, cur;
        tbl[0] = '{32'h8C01_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        tbl[1] = '{32'h0800_0008, 1'b1, 1'b0, 1'b0, 32'h0000_0020};
        tbl[2] = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_001C};
        tbl[3] = '{32'h0800_0008, 1'b1, 1'b0, 1'b0, 32'h0000_0020};
        tbl[4] = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0024};
        tbl[5] = '{32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 32'h0000_0028};
        tbl[6] = '{32'h0800_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        tbl[7] = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC};
        tbl[8] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        tbl[9] = '{32'hAC22_0008, 1'b0, 1'b1, 1'b1, 32'h0000_0024};
        apply_reset();
        cur = 32'h0;
        for (int i = 0; i < 10; i++) begin
            wait_req(ok, a, ah);
            total++;
            if (!ok || a !== cur || ah !== mpc_h) begin
                bad++; $display("FAIL tbl_req[%0d] ok=%0d addr=%h addr_h=%h want %h/%h", i, ok, a, ah, cur, mpc_h);
            end
            deliver(tbl[i].data, i % 3);
            total++;
            if (instr_valid !== 1'b1 || instr !== tbl[i].data || pc !== cur || pc_plus4 !== cur + 32'd4) begin
                bad++; $display("FAIL tbl_issue[%0d] valid=%b instr=%h pc=%h pc4=%h want 1/%h/%h/%h",
                                i, instr_valid, instr, pc, pc_plus4, tbl[i].data, cur, cur + 32'd4);
            end
            execute(tbl[i].data, tbl[i].j, tbl[i].b, tbl[i].z);
            cur = tbl[i].exp;
        end
        wait_req(ok, a, ah);
        total++;
        if (!ok || a !== cur) begin
            bad++; $display("FAIL tbl_final ok=%0d addr=%h want=%h", ok, a, cur);
        end
    endtask

    task automatic test_timeout();
        bit ok; logic [31:0] a, ah;
        int reqs;
        apply_reset();
        wait_req(ok, a, ah);
        repeat (15) @(negedge clk);
        total++;
        if (fetch_err !== 1'b0) begin
            bad++; $display("FAIL timeout_early got=%b want=0 after 14 idle waits", fetch_err);
        end
        @(negedge clk);
        total++;
        if (fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_set err=%b valid=%b want 1/0", fetch_err, instr_valid);
        end
        reqs = 0;
        for (int i = 0; i < 30; i++) begin
            imem_rvalid = 1'($urandom); ex_done = 1'($urandom); imem_rdata = $urandom;
            @(negedge clk);
            if (imem_req || instr_valid) reqs++;
        end
        clear_inputs();
        total++;
        if (reqs !== 0 || fetch_err !== 1'b1) begin
            bad++; $display("FAIL halt_quiet activity=%0d err=%b want 0/1", reqs, fetch_err);
        end
        apply_reset();
        total++;
        if (fetch_err !== 1'b0) begin
            bad++; $display("FAIL timeout_clear got=%b want=0", fetch_err);
        end
        wait_req(ok, a, ah);
        total++;
        if (!ok || a !== 32'h0) begin
            bad++; $display("FAIL halt_restart ok=%0d addr=%h want addr=0", ok, a);
        end
        // rvalid in the last allowed wait cycle is still accepted
        repeat (15) @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
        @(negedge clk);
        imem_rvalid = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin
            bad++; $display("FAIL late_rvalid valid=%b err=%b want 1/0", instr_valid, fetch_err);
        end
    endtask

    task automatic test_reset_mid_issue();
        bit ok; logic [31:0] a, ah, addr_seen;
        int reqs; bit valid_seen;
        apply_reset();
        wait_req(ok, a, ah);
        deliver(32'h8C01_0004, 0);
        execute(32'h8C01_0004, 1'b0, 1'b0, 1'b0);
        wait_req(ok, a, ah);
        deliver(32'h0000_0020, 2);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL async_reset pc=%h valid=%b req=%b want 0/0/0", pc, instr_valid, imem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
        @(negedge clk);
        imem_rvalid = 1'b0;
        reqs = 0; valid_seen = 1'b0; addr_seen = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            if (imem_req) begin reqs++; addr_seen = imem_addr; end
            if (instr_valid) valid_seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (reqs !== 1 || valid_seen !== 1'b0 || addr_seen !== 32'h0) begin
            bad++; $display("FAIL stray_rvalid reqs=%0d valid=%b addr=%h want 1/0/0", reqs, valid_seen, addr_seen);
        end
    endtask

    task automatic test_unknown_opcode();
        bit ok; logic [31:0] a, ah;
        apply_reset();
        wait_req(ok, a, ah);
        deliver(32'hFC00_1234, 0);
`ifdef IFU_ILLEGAL_TRAP_EN
        total++;
        if (illegal_op !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h0) begin
            bad++; $display("FAIL illegal_trap ill=%b valid=%b pc=%h want 1/0/0", illegal_op, instr_valid, pc);
        end
        repeat (5) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || illegal_op !== 1'b1) begin
            bad++; $display("FAIL illegal_halt req=%b ill=%b want 0/1", imem_req, illegal_op);
        end
`else
        total++;
        if (instr_valid !== 1'b1 || opcode !== 6'b111111) begin
            bad++; $display("FAIL unknown_issue valid=%b op=%b want 1/111111", instr_valid, opcode);
        end
        execute(32'hFC00_1234, 1'b0, 1'b0, 1'b0);
        wait_req(ok, a, ah);
        total++;
        if (!ok || a !== 32'h4) begin
            bad++; $display("FAIL unknown_next ok=%0d addr=%h want 4", ok, a);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0]  ops[5];
        logic [31:0] r, data, a, ah;
        bit ok, j, b, z;
        int lat, hold;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100; ops[4] = 6'b000010;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            r    = $urandom;
            data = {ops[$urandom_range(0, 4)], r[25:0]};
            lat  = $urandom_range(0, 6);
            wait_req(ok, a, ah);
            total++;
            if (!ok || a !== mpc || ah !== mpc_h) begin
                bad++; $display("FAIL rnd_req[%0d] ok=%0d addr=%h addr_h=%h want %h/%h", n, ok, a, ah, mpc, mpc_h);
            end
            deliver(data, lat);
            total++;
            if (instr_valid !== 1'b1 || instr !== data || opcode !== data[31:26] ||
                pc !== mpc || pc_plus4 !== mpc + 32'd4) begin
                bad++; $display("FAIL rnd_issue[%0d] valid=%b instr=%h pc=%h pc4=%h want 1/%h/%h/%h",
                                n, instr_valid, instr, pc, pc_plus4, data, mpc, mpc + 32'd4);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
                imem_rvalid = 1'($urandom); imem_rdata = $urandom;
                @(negedge clk);
                total++;
                if (instr_valid !== 1'b1 || instr !== data || imem_req !== 1'b0) begin
                    bad++; $display("FAIL rnd_hold[%0d] valid=%b instr=%h req=%b want 1/%h/0",
                                    n, instr_valid, instr, imem_req, data);
                end
            end
            j = 1'($urandom); b = 1'($urandom); z = 1'($urandom);
            execute(data, j, b, z);
        end
        wait_req(ok, a, ah);
        total++;
        if (!ok || a !== mpc) begin
            bad++; $display("FAIL rnd_final ok=%0d addr=%h want=%h", ok, a, mpc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_lw_latency();
        test_jump_priority();
        test_next_pc_table();
        test_timeout();
        test_reset_mid_issue();
        test_unknown_opcode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
